// File: rtl/nw_pkg.sv
// nw_pkg: shared symbol/op/state encodings and width helpers for the traceback controller.
package nw_pkg;
  localparam logic [2:0] SYM_DIAG = 3'b001;
  localparam logic [2:0] SYM_UP   = 3'b010;
  localparam logic [2:0] SYM_LEFT = 3'b100;
  localparam logic [1:0] OP_DIAG = 2'b00;
  localparam logic [1:0] OP_UP   = 2'b01;
  localparam logic [1:0] OP_LEFT = 2'b10;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_EMIT = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
  localparam logic [2:0] S_ERR  = 3'd5;
  function automatic int nw_width(input int v);
    return (v < 2) ? 1 : $clog2(v);
  endfunction
  // Anything that is not a clean UP or LEFT falls back to a diagonal step.
  function automatic logic [1:0] nw_decode(input logic [2:0] s);
    return (s == SYM_UP) ? OP_UP : (s == SYM_LEFT) ? OP_LEFT : OP_DIAG;
  endfunction
  function automatic logic nw_legal(input logic [2:0] s);
    return (s == SYM_DIAG) || (s == SYM_UP) || (s == SYM_LEFT);
  endfunction
endpackage

// File: rtl/tb_addr_gen.sv
// tb_addr_gen: flattened direction-memory address i*(N+1)+j via shift-add, registered.
module tb_addr_gen #(
  parameter int N  = 128,
  parameter int IW = 8,
  parameter int AW = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [IW-1:0] i_i,
  input  logic [IW-1:0] j_i,
  output logic [AW-1:0] addr_o
);
  logic [AW-1:0] sum;
  always_comb begin
    sum = AW'(j_i);
    for (int b = 0; b < IW + 1; b++)
      sum = (((N + 1) >> b) % 2 == 1) ? sum + (AW'(i_i) << b) : sum;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) addr_o <= '0;
    else addr_o <= sum;
  end
endmodule

// File: rtl/traceback_ctrl.sv
// traceback_ctrl: Needleman-Wunsch traceback walker from (N,N) to (0,0), one op per step.
// Define TB_ERRCHK_EN to trap illegal direction symbols in a sticky ERR state.
module traceback_ctrl import nw_pkg::*; #(
  parameter int N = 128,
  parameter int RD_LAT = 1,
  localparam int IW = nw_width(N + 1),
  localparam int AW = nw_width((N + 1) * (N + 1))
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          mem_rd_en,
  output logic [AW-1:0] mem_addr,
  input  logic [2:0]    mem_sym,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [1:0]    out_op,
  output logic [IW-1:0] i,
  output logic [IW-1:0] j,
  output logic [IW:0]   path_len,
  output logic          err
);
  localparam int CW = nw_width(RD_LAT + 1);
  logic [2:0] state_q, state_d;
  logic [IW-1:0] i_q, i_d, j_q, j_d;
  logic [IW:0] len_q, len_d;
  logic [1:0] op_q, op_d;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    state_d = state_q;
    i_d = i_q;
    j_d = j_q;
    len_d = len_q;
    op_d = op_q;
    cnt_d = cnt_q;
    case (state_q)
      S_IDLE, S_ERR: if (start) begin
        i_d = IW'(N);
        j_d = IW'(N);
        len_d = '0;
        state_d = S_RD;
      end
      S_RD: begin
        op_d = (i_q == '0) ? OP_LEFT : OP_UP;
        cnt_d = '0;
        state_d = (i_q == '0 && j_q == '0) ? S_DONE : (i_q == '0 || j_q == '0) ? S_EMIT : S_WAIT;
      end
      S_WAIT: if (cnt_q == CW'(RD_LAT - 1)) begin
        op_d = nw_decode(mem_sym);
        state_d = S_EMIT;
`ifdef TB_ERRCHK_EN
        if (!nw_legal(mem_sym)) state_d = S_ERR;
`endif
      end else cnt_d = cnt_q + 1'b1;
      S_EMIT: if (out_ready) begin
        i_d = i_q - IW'(op_q != OP_LEFT);
        j_d = j_q - IW'(op_q != OP_UP);
        len_d = len_q + 1'b1;
        state_d = S_RD;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      i_q <= '0;
      j_q <= '0;
      len_q <= '0;
      op_q <= OP_DIAG;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      i_q <= i_d;
      j_q <= j_d;
      len_q <= len_d;
      op_q <= op_d;
      cnt_q <= cnt_d;
    end
  end
  // Address is built from next-state coordinates so it is ready in the RD cycle.
  tb_addr_gen #(.N(N), .IW(IW), .AW(AW)) u_addr (
    .clk(clk), .rst_n(rst_n), .i_i(i_d), .j_i(j_d), .addr_o(mem_addr)
  );
`ifdef TB_ERRCHK_EN
  logic err_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else err_q <= (state_d == S_ERR);
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif
  assign busy = (state_q == S_RD) || (state_q == S_WAIT) || (state_q == S_EMIT);
  assign done = (state_q == S_DONE);
  assign mem_rd_en = (state_q == S_RD) && (i_q != '0) && (j_q != '0);
  assign out_valid = (state_q == S_EMIT);
  assign out_op = op_q;
  assign i = i_q;
  assign j = j_q;
  assign path_len = len_q;
endmodule
